// File: rtl/hill_block_loader.sv
// Front end for the Hill-cipher core: loads the key matrix, filters letters into
// fixed-size blocks, pads the tail block and hands each block to the core.
module hill_block_loader #(
    parameter int                    BLOCK_SIZE = 3,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_CHAR   = 8'h58,
    localparam int KEY_N   = BLOCK_SIZE * BLOCK_SIZE,
    localparam int KEY_AW  = (KEY_N > 1) ? $clog2(KEY_N) : 1,
    localparam int TEXT_AW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode_in,
    input  logic [DATA_WIDTH-1:0] key_in,
    input  logic                  key_in_valid,
    output logic                  key_in_ready,
    input  logic [DATA_WIDTH-1:0] char_in,
    input  logic                  char_valid,
    input  logic                  char_last,
    output logic                  char_ready,
    output logic [DATA_WIDTH-1:0] key_data,
    output logic [KEY_AW-1:0]     key_addr,
    output logic                  key_wen,
    output logic [DATA_WIDTH-1:0] text_in,
    output logic [TEXT_AW-1:0]    text_in_addr,
    output logic                  text_in_wen,
    output logic                  start,
    output logic                  mode,
    input  logic                  cipher_done,
    output logic                  key_loaded,
    output logic                  busy,
    output logic [15:0]           blocks_sent,
    output logic [15:0]           dropped
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_KICK, S_WAIT} state_t;

    localparam logic [KEY_AW-1:0]     KEY_LAST  = KEY_AW'(KEY_N - 1);
    localparam logic [TEXT_AW-1:0]    FILL_LAST = TEXT_AW'(BLOCK_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] UPPER_A   = DATA_WIDTH'(8'h41);
    localparam logic [DATA_WIDTH-1:0] UPPER_Z   = DATA_WIDTH'(8'h5A);
    localparam logic [DATA_WIDTH-1:0] LOWER_A   = DATA_WIDTH'(8'h61);
    localparam logic [DATA_WIDTH-1:0] LOWER_Z   = DATA_WIDTH'(8'h7A);

    state_t                  state, state_nxt;
    logic [KEY_AW-1:0]       key_cnt, key_cnt_nxt;
    logic [TEXT_AW-1:0]      fill_cnt, fill_cnt_nxt;
    logic                    key_loaded_nxt, mode_nxt, start_nxt;
    logic                    key_wen_nxt, text_in_wen_nxt;
    logic [DATA_WIDTH-1:0]   key_data_nxt, text_in_nxt;
    logic [KEY_AW-1:0]       key_addr_nxt;
    logic [TEXT_AW-1:0]      text_in_addr_nxt;
    logic [15:0]             blocks_sent_nxt, dropped_nxt;
    logic                    key_fire, char_fire;

    function automatic logic is_letter(input logic [DATA_WIDTH-1:0] c);
        return ((c >= UPPER_A) && (c <= UPPER_Z)) || ((c >= LOWER_A) && (c <= LOWER_Z));
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Key bytes only flow between blocks; text waits until the key is complete.
    assign key_in_ready = (state == S_FILL) && (fill_cnt == '0);
    assign char_ready   = (state == S_FILL) && key_loaded && (key_cnt == '0) && !key_in_valid;
    assign key_fire     = key_in_valid && key_in_ready;
    assign char_fire    = char_valid && char_ready;
    assign busy         = (state != S_FILL) || (fill_cnt != '0);

    always_comb begin
        state_nxt        = state;
        key_cnt_nxt      = key_cnt;
        fill_cnt_nxt     = fill_cnt;
        key_loaded_nxt   = key_loaded;
        mode_nxt         = mode;
        start_nxt        = 1'b0;
        key_wen_nxt      = 1'b0;
        key_data_nxt     = key_data;
        key_addr_nxt     = key_addr;
        text_in_wen_nxt  = 1'b0;
        text_in_nxt      = text_in;
        text_in_addr_nxt = text_in_addr;
        blocks_sent_nxt  = blocks_sent;
        dropped_nxt      = dropped;

        unique case (state)
            S_FILL: begin
                if (key_fire) begin
                    key_wen_nxt  = 1'b1;
                    key_data_nxt = key_in;
                    key_addr_nxt = key_cnt;
                    if (key_cnt == '0) key_loaded_nxt = 1'b0;
                    if (key_cnt == KEY_LAST) begin
                        key_cnt_nxt    = '0;
                        key_loaded_nxt = 1'b1;
                    end else begin
                        key_cnt_nxt = key_cnt + 1'b1;
                    end
                end else if (char_fire) begin
                    if (is_letter(char_in)) begin
                        text_in_wen_nxt  = 1'b1;
                        text_in_nxt      = char_in;
                        text_in_addr_nxt = fill_cnt;
                        if (fill_cnt == '0) mode_nxt = mode_in;
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt_nxt = '0;
                            state_nxt    = S_KICK;
                        end else begin
                            fill_cnt_nxt = fill_cnt + 1'b1;
                            if (char_last) state_nxt = S_PAD;
                        end
                    end else begin
                        dropped_nxt = sat_inc(dropped);
                        // A message ending on a dropped byte still closes a partial block.
                        if (char_last && (fill_cnt != '0)) state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                text_in_wen_nxt  = 1'b1;
                text_in_nxt      = PAD_CHAR;
                text_in_addr_nxt = fill_cnt;
                if (fill_cnt == FILL_LAST) begin
                    fill_cnt_nxt = '0;
                    state_nxt    = S_KICK;
                end else begin
                    fill_cnt_nxt = fill_cnt + 1'b1;
                end
            end
            S_KICK: begin
                start_nxt       = 1'b1;
                blocks_sent_nxt = blocks_sent + 16'd1;
                state_nxt       = S_WAIT;
            end
            S_WAIT: begin
                if (cipher_done) state_nxt = S_FILL;
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FILL;
            key_cnt      <= '0;
            fill_cnt     <= '0;
            key_loaded   <= 1'b0;
            mode         <= 1'b0;
            start        <= 1'b0;
            key_wen      <= 1'b0;
            key_data     <= '0;
            key_addr     <= '0;
            text_in_wen  <= 1'b0;
            text_in      <= '0;
            text_in_addr <= '0;
            blocks_sent  <= '0;
            dropped      <= '0;
        end else begin
            state        <= state_nxt;
            key_cnt      <= key_cnt_nxt;
            fill_cnt     <= fill_cnt_nxt;
            key_loaded   <= key_loaded_nxt;
            mode         <= mode_nxt;
            start        <= start_nxt;
            key_wen      <= key_wen_nxt;
            key_data     <= key_data_nxt;
            key_addr     <= key_addr_nxt;
            text_in_wen  <= text_in_wen_nxt;
            text_in      <= text_in_nxt;
            text_in_addr <= text_in_addr_nxt;
            blocks_sent  <= blocks_sent_nxt;
            dropped      <= dropped_nxt;
        end
    end

endmodule

// File: tb/tb_hill_block_loader.sv
// Directed bench for hill_block_loader; the bench plays the cipher core's done handshake.
module tb_hill_block_loader;

    localparam int KEY_AW  = 4;
    localparam int TEXT_AW = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode_in;
    logic [7:0]         key_in;
    logic               key_in_valid;
    logic               key_in_ready;
    logic [7:0]         char_in;
    logic               char_valid;
    logic               char_last;
    logic               char_ready;
    logic [7:0]         key_data;
    logic [KEY_AW-1:0]  key_addr;
    logic               key_wen;
    logic [7:0]         text_in;
    logic [TEXT_AW-1:0] text_in_addr;
    logic               text_in_wen;
    logic               start;
    logic               mode;
    logic               cipher_done;
    logic               key_loaded;
    logic               busy;
    logic [15:0]        blocks_sent;
    logic [15:0]        dropped;

    int checks = 0;
    int errors = 0;

    logic [7:0] key_bytes [9] = '{8'd6, 8'd24, 8'd1, 8'd13, 8'd16, 8'd10, 8'd20, 8'd17, 8'd15};

    hill_block_loader #(.BLOCK_SIZE(3), .DATA_WIDTH(8), .PAD_CHAR(8'h58)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in),
        .key_in(key_in), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
        .char_in(char_in), .char_valid(char_valid), .char_last(char_last), .char_ready(char_ready),
        .key_data(key_data), .key_addr(key_addr), .key_wen(key_wen),
        .text_in(text_in), .text_in_addr(text_in_addr), .text_in_wen(text_in_wen),
        .start(start), .mode(mode), .cipher_done(cipher_done),
        .key_loaded(key_loaded), .busy(busy), .blocks_sent(blocks_sent), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input logic last);
        char_in = c; char_valid = 1'b1; char_last = last;
        #1;
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL char_ready_before_%c: got %0b exp 1", c, char_ready); end
        tick();
        char_valid = 1'b0; char_last = 1'b0;
    endtask

    task automatic pulse_done();
        cipher_done = 1'b1;
        tick();
        cipher_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL rst_key_loaded: got %0b exp 0", key_loaded); end
        checks++; if ({start, key_wen, text_in_wen, mode} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b exp 0000", {start, key_wen, text_in_wen, mode}); end
        checks++; if ({blocks_sent, dropped} !== 32'h0) begin errors++; $display("FAIL rst_counters: got %h exp 0", {blocks_sent, dropped}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", busy); end
        #2 rst_n = 1'b1;
        tick();
        checks++; if (key_in_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready: got %0b exp 1", key_in_ready); end
        checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL rst_char_ready: got %0b exp 0", char_ready); end
    endtask

    task automatic test_key_load();
        int bad = 0;
        for (int i = 0; i < 9; i++) begin
            key_in = key_bytes[i]; key_in_valid = 1'b1;
            #1;
            if (char_ready !== 1'b0 || key_in_ready !== 1'b1) bad++;
            tick();
            checks++;
            if (key_wen !== 1'b1 || key_addr !== KEY_AW'(i) || key_data !== key_bytes[i] || key_loaded !== (i == 8)) begin
                errors++;
                $display("FAIL key_write_%0d: got wen=%0b addr=%0d data=%0d loaded=%0b exp wen=1 addr=%0d data=%0d loaded=%0b",
                         i, key_wen, key_addr, key_data, key_loaded, i, key_bytes[i], (i == 8));
            end
        end
        key_in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL key_ready_during_load: got %0d bad cycles exp 0", bad); end
        tick();
        checks++; if (key_wen !== 1'b0) begin errors++; $display("FAIL key_wen_single: got %0b exp 0", key_wen); end
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL char_ready_after_key: got %0b exp 1", char_ready); end
    endtask

    task automatic test_full_block();
        mode_in = 1'b0;
        send_char(8'h41, 1'b0);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd0 || text_in !== 8'h41) begin errors++; $display("FAIL act_w0: got wen=%0b addr=%0d data=%h exp 1/0/41", text_in_wen, text_in_addr, text_in); end
        checks++; if (busy !== 1'b1 || mode !== 1'b0) begin errors++; $display("FAIL act_busy_mode: got busy=%0b mode=%0b exp 1/0", busy, mode); end
        send_char(8'h43, 1'b0);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd1 || text_in !== 8'h43) begin errors++; $display("FAIL act_w1: got wen=%0b addr=%0d data=%h exp 1/1/43", text_in_wen, text_in_addr, text_in); end
        send_char(8'h54, 1'b1);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd2 || text_in !== 8'h54 || start !== 1'b0) begin errors++; $display("FAIL act_w2: got wen=%0b addr=%0d data=%h start=%0b exp 1/2/54/0", text_in_wen, text_in_addr, text_in, start); end
        tick();
        checks++; if (start !== 1'b1 || text_in_wen !== 1'b0 || blocks_sent !== 16'd1) begin errors++; $display("FAIL act_start: got start=%0b wen=%0b blocks=%0d exp 1/0/1", start, text_in_wen, blocks_sent); end
        tick();
        checks++; if (start !== 1'b0 || char_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL act_wait: got start=%0b ready=%0b busy=%0b exp 0/0/1", start, char_ready, busy); end
        pulse_done();
        checks++; if (char_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL act_resume: got ready=%0b busy=%0b exp 1/0", char_ready, busy); end
    endtask

    task automatic test_pad();
        mode_in = 1'b1;
        send_char(8'h61, 1'b0);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd0 || text_in !== 8'h61 || mode !== 1'b1) begin errors++; $display("FAIL pad_w0: got wen=%0b addr=%0d data=%h mode=%0b exp 1/0/61/1", text_in_wen, text_in_addr, text_in, mode); end
        send_char(8'h2D, 1'b0);
        checks++; if (text_in_wen !== 1'b0 || dropped !== 16'd1) begin errors++; $display("FAIL pad_drop: got wen=%0b dropped=%0d exp 0/1", text_in_wen, dropped); end
        send_char(8'h62, 1'b1);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd1 || text_in !== 8'h62) begin errors++; $display("FAIL pad_w1: got wen=%0b addr=%0d data=%h exp 1/1/62", text_in_wen, text_in_addr, text_in); end
        tick();
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd2 || text_in !== 8'h58 || start !== 1'b0) begin errors++; $display("FAIL pad_w2: got wen=%0b addr=%0d data=%h start=%0b exp 1/2/58/0", text_in_wen, text_in_addr, text_in, start); end
        tick();
        checks++; if (start !== 1'b1 || text_in_wen !== 1'b0 || blocks_sent !== 16'd2) begin errors++; $display("FAIL pad_start: got start=%0b wen=%0b blocks=%0d exp 1/0/2", start, text_in_wen, blocks_sent); end
        tick();
        pulse_done();
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        mode_in = 1'b0;
        send_char(8'h41, 1'b0);
        send_char(8'h43, 1'b0);
        send_char(8'h54, 1'b0);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd2 || text_in !== 8'h54) begin errors++; $display("FAIL b2b_w2: got wen=%0b addr=%0d data=%h exp 1/2/54", text_in_wen, text_in_addr, text_in); end
        tick();
        checks++; if (start !== 1'b1 || blocks_sent !== 16'd3 || mode !== 1'b0) begin errors++; $display("FAIL b2b_start1: got start=%0b blocks=%0d mode=%0b exp 1/3/0", start, blocks_sent, mode); end
        char_in = 8'h47; char_valid = 1'b1; mode_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (char_ready !== 1'b0 || key_in_ready !== 1'b0 || text_in_wen !== 1'b0 || key_wen !== 1'b0 || start !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_wait_quiet: got %0d bad cycles exp 0", bad); end
        pulse_done();
        checks++; if (char_ready !== 1'b1) begin errors++; $display("FAIL b2b_resume: got %0b exp 1", char_ready); end
        send_char(8'h47, 1'b0);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd0 || text_in !== 8'h47 || mode !== 1'b1) begin errors++; $display("FAIL b2b_g: got wen=%0b addr=%0d data=%h mode=%0b exp 1/0/47/1", text_in_wen, text_in_addr, text_in, mode); end
        send_char(8'h4F, 1'b1);
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd1 || text_in !== 8'h4F) begin errors++; $display("FAIL b2b_o: got wen=%0b addr=%0d data=%h exp 1/1/4f", text_in_wen, text_in_addr, text_in); end
        tick();
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd2 || text_in !== 8'h58) begin errors++; $display("FAIL b2b_pad: got wen=%0b addr=%0d data=%h exp 1/2/58", text_in_wen, text_in_addr, text_in); end
        tick();
        checks++; if (start !== 1'b1 || blocks_sent !== 16'd4 || mode !== 1'b1) begin errors++; $display("FAIL b2b_start2: got start=%0b blocks=%0d mode=%0b exp 1/4/1", start, blocks_sent, mode); end
        tick();
        pulse_done();
    endtask

    task automatic test_last_empty();
        send_char(8'h21, 1'b1);
        checks++; if (text_in_wen !== 1'b0 || dropped !== 16'd2 || busy !== 1'b0) begin errors++; $display("FAIL empty_last: got wen=%0b dropped=%0d busy=%0b exp 0/2/0", text_in_wen, dropped, busy); end
        tick();
        checks++; if (start !== 1'b0 || char_ready !== 1'b1 || blocks_sent !== 16'd4) begin errors++; $display("FAIL empty_nostart: got start=%0b ready=%0b blocks=%0d exp 0/1/4", start, char_ready, blocks_sent); end
    endtask

    task automatic test_priority();
        key_in = 8'h55; key_in_valid = 1'b1;
        char_in = 8'h51; char_valid = 1'b1;
        #1;
        checks++; if (char_ready !== 1'b0 || key_in_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got char=%0b key=%0b exp 0/1", char_ready, key_in_ready); end
        tick();
        key_in_valid = 1'b0;
        checks++; if (key_wen !== 1'b1 || key_addr !== 4'd0 || key_data !== 8'h55 || key_loaded !== 1'b0 || text_in_wen !== 1'b0) begin errors++; $display("FAIL prio_key: got wen=%0b addr=%0d data=%h loaded=%0b twen=%0b exp 1/0/55/0/0", key_wen, key_addr, key_data, key_loaded, text_in_wen); end
        #1;
        checks++; if (char_ready !== 1'b0) begin errors++; $display("FAIL prio_char_blocked: got %0b exp 0", char_ready); end
        char_valid = 1'b0;
    endtask

    task automatic test_reset_pad();
        for (int i = 1; i < 9; i++) begin
            key_in = key_bytes[i]; key_in_valid = 1'b1;
            tick();
        end
        key_in_valid = 1'b0;
        checks++; if (key_loaded !== 1'b1 || key_addr !== 4'd8) begin errors++; $display("FAIL reload_key: got loaded=%0b addr=%0d exp 1/8", key_loaded, key_addr); end
        mode_in = 1'b1;
        send_char(8'h5A, 1'b1);
        tick();
        checks++; if (text_in_wen !== 1'b1 || text_in_addr !== 2'd1 || text_in !== 8'h58 || mode !== 1'b1) begin errors++; $display("FAIL rpad_pre: got wen=%0b addr=%0d data=%h mode=%0b exp 1/1/58/1", text_in_wen, text_in_addr, text_in, mode); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({key_loaded, start, key_wen, text_in_wen, mode, busy} !== 6'b0) begin errors++; $display("FAIL rpad_ctrl: got %b exp 000000", {key_loaded, start, key_wen, text_in_wen, mode, busy}); end
        checks++; if (key_data !== 8'h0 || key_addr !== 4'd0 || text_in !== 8'h0 || text_in_addr !== 2'd0) begin errors++; $display("FAIL rpad_ports: got kd=%h ka=%0d t=%h ta=%0d exp 0", key_data, key_addr, text_in, text_in_addr); end
        checks++; if (blocks_sent !== 16'd0 || dropped !== 16'd0) begin errors++; $display("FAIL rpad_counters: got blocks=%0d dropped=%0d exp 0/0", blocks_sent, dropped); end
        rst_n = 1'b1;
        char_in = 8'h41; char_valid = 1'b1;
        tick();
        checks++; if (key_loaded !== 1'b0 || char_ready !== 1'b0 || key_in_ready !== 1'b1 || text_in_wen !== 1'b0) begin errors++; $display("FAIL rpad_after: got loaded=%0b cready=%0b kready=%0b twen=%0b exp 0/0/1/0", key_loaded, char_ready, key_in_ready, text_in_wen); end
        char_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode_in = 1'b0;
        key_in = '0; key_in_valid = 1'b0;
        char_in = '0; char_valid = 1'b0; char_last = 1'b0;
        cipher_done = 1'b0;
        test_reset();
        test_key_load();
        test_full_block();
        test_pad();
        test_back_to_back();
        test_last_empty();
        test_priority();
        test_reset_pad();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hill_block_loader.md
Name: hill_block_loader

Overview:
- Upstream feeder for the Hill-cipher matrix core.
- Accepts a byte stream of key bytes and a ready/valid stream of ASCII text, then drives the core's key and text write ports.
- Drops non-letters and groups letters into BLOCK_SIZE-character blocks, padding the final partial block with PAD_CHAR.
- For each block it pulses start and waits for the core's done before loading the next block.

Parameters:
BLOCK_SIZE, 3, characters per block; key is BLOCK_SIZE*BLOCK_SIZE bytes
DATA_WIDTH, 8, width of the key, char and text buses
PAD_CHAR, 8'h58 ("X"), filler written into unfilled slots of the last block

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
mode_in  in  1  encrypt/decrypt select; sampled when the first char of a block is accepted
key_in  in  DATA_WIDTH  key byte, row-major order
key_in_valid  in  1  key byte present
key_in_ready  out  1  key byte accepted when valid&&ready
char_in  in  DATA_WIDTH  ASCII text byte
char_valid  in  1  text byte present
char_last  in  1  marks the final byte of a message
char_ready  out  1  text byte accepted when valid&&ready
key_data  out  DATA_WIDTH  to core key write port
key_addr  out  clog2(BLOCK_SIZE^2)  to core
key_wen  out  1  to core
text_in  out  DATA_WIDTH  to core (raw ASCII; core converts to a number)
text_in_addr  out  clog2(BLOCK_SIZE)  to core
text_in_wen  out  1  to core
start  out  1  one-cycle pulse to core
mode  out  1  to core; held stable from start until cipher_done
cipher_done  in  1  core done pulse
key_loaded  out  1  full key has been written
busy  out  1  state != FILL or fill_cnt != 0
blocks_sent  out  16  count of start pulses, wraps at 2^16
dropped  out  16  count of discarded non-letter bytes, saturates at FFFF

Behaviour:
- Reset (async, rst_n=0): state=FILL; key_cnt=0; fill_cnt=0.
  - All outputs 0: key_loaded, start, key_wen, text_in_wen, key_data, key_addr, text_in, text_in_addr, mode, blocks_sent, dropped.
  - Reset mid-block or mid-key abandons that work; the key must be reloaded.
- States: FILL, PAD, KICK, WAIT.
- Write-port outputs (key_*, text_*) are registered. Each wen is high exactly one cycle, in the cycle after the accepting handshake, with addr/data valid in that same cycle.
- key_in_ready = (state==FILL) && (fill_cnt==0).
  - Accepting a key byte writes key_addr=key_cnt, then key_cnt++.
  - The first byte of a new key (key_cnt==0) clears key_loaded.
  - At key_cnt==BLOCK_SIZE^2-1 the counter wraps to 0 and key_loaded=1.
- char_ready = (state==FILL) && key_loaded && (key_cnt==0) && !key_in_valid. Key traffic has priority over text.
- FILL, accepted byte:
  - Letter (A-Z or a-z): text_in=char_in, text_in_addr=fill_cnt, fill_cnt++. On the first letter of a block, latch mode_in into mode.
  - Non-letter: no write; dropped++.
  - If fill_cnt reaches BLOCK_SIZE, go to KICK (fill_cnt returns to 0).
  - Else, if char_last and 0<fill_cnt, go to PAD.
  - char_last with fill_cnt==0 after the byte: no block is sent; stay in FILL.
- PAD: char_ready=0. Each cycle write PAD_CHAR at addr fill_cnt, fill_cnt++; after writing addr BLOCK_SIZE-1, go to KICK.
- KICK: start=1 for exactly one cycle, which is the cycle after the final text_in_wen. blocks_sent++, then go to WAIT.
- WAIT: all readies 0 and all wens 0. On cipher_done go to FILL; char_ready may assert the next cycle.
- cipher_done seen outside WAIT is ignored.
- Block-to-block turnaround: FILL resumes the cycle after cipher_done; no bubble beyond that cycle.
- Counters are 16 bits: blocks_sent wraps, dropped saturates.

Test Plan:
- Load key bytes 6,24,1,13,16,10,20,17,15 -> key_wen pulses 9 times at addr 0..8; key_loaded=1 after the 9th; char_ready stays 0 until then.
- Send "ACT" with char_last on T, mode_in=0 -> text_in_wen at addr 0,1,2 with A,C,T; start pulses once the cycle after; with the real core, text_out yields "POH"; blocks_sent=1.
- Send "a-b" with last on b -> writes a@0, b@1, PAD "X"@2, then start; dropped=1.
- Send "ACTGO" with last on O while the core holds done off for 50 cycles -> char_ready=0 throughout WAIT. After done, "GO"+"X" is sent; mode is re-sampled per block; blocks_sent=2.
- Assert key_in_valid and char_valid together with fill_cnt==0 and key_loaded=1 -> key byte wins and key_loaded drops.
- Assert rst_n low during PAD -> all outputs 0 immediately; after release, key_loaded=0 and char_ready=0.
